// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
// Write-port arbiter and pending-write scoreboard for the register file.
// Two writeback requesters (ALU result, memory load) each fill a one-entry
// holding buffer through a valid/ready handshake. One buffer per cycle is
// granted into a registered output stage that drives the register file write
// port. A per-register pending bitmap lets the control unit stall dependents.
//
// Build option: define RR_ARB_EN for round-robin arbitration between the two
// buffers. Leave it undefined for fixed priority, MEM over ALU.
// Two full buffers holding the same address always drain oldest first; on a
// tie MEM goes first, so the ALU value is the last one written.
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   ALU_VALID/ADDR/DATA/READY  ALU writeback handshake
//   MEM_VALID/ADDR/DATA/READY  memory-load writeback handshake
//   ISSUE_VALID/ADDR           issued instruction destination (sets PENDING)
//   WRITE/INADDRESS/IN         registered register file write port
//   PENDING                    bit i set while register i has a write in flight
module reg_write_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ALU_VALID,
  input  logic [ADDR_W-1:0]          ALU_ADDR,
  input  logic [DATA_W-1:0]          ALU_DATA,
  output logic                       ALU_READY,
  input  logic                       MEM_VALID,
  input  logic [ADDR_W-1:0]          MEM_ADDR,
  input  logic [DATA_W-1:0]          MEM_DATA,
  output logic                       MEM_READY,
  input  logic                       ISSUE_VALID,
  input  logic [ADDR_W-1:0]          ISSUE_ADDR,
  output logic                       WRITE,
  output logic [ADDR_W-1:0]          INADDRESS,
  output logic [DATA_W-1:0]          IN,
  output logic [(1 << ADDR_W)-1:0]   PENDING
);

  localparam int unsigned NREG = 1 << ADDR_W;

  // One holding-buffer entry; age=1 means older than the other full buffer.
  typedef struct packed {
    logic              full;
    logic              age;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_buf_t;

  wb_buf_t alu_buf;
  wb_buf_t mem_buf;

  logic grant_alu_c;
  logic grant_mem_c;
  logic pri_mem_c;
  logic alu_load_c;
  logic mem_load_c;
  logic alu_stay_c;
  logic mem_stay_c;
  logic [NREG-1:0] pending_nxt_c;

`ifdef RR_ARB_EN
  // Last-grant register: 1 = MEM granted last, 0 = ALU granted last.
  logic last_grant_mem;

  // Priority goes to the requester that was not granted last.
  assign pri_mem_c = !last_grant_mem;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant_mem <= 1'b0;
    end else if (grant_alu_c || grant_mem_c) begin
      last_grant_mem <= grant_mem_c;
    end
  end
`else
  assign pri_mem_c = 1'b1;
`endif

  // Arbitration over full buffers; same-address ordering overrides priority.
  always_comb begin
    grant_alu_c = 1'b0;
    grant_mem_c = 1'b0;
    if (alu_buf.full && mem_buf.full) begin
      if (alu_buf.addr == mem_buf.addr) begin
        // Equal ages means both accepted together: MEM drains first.
        grant_alu_c = alu_buf.age;
      end else begin
        grant_alu_c = !pri_mem_c;
      end
      grant_mem_c = !grant_alu_c;
    end else begin
      grant_alu_c = alu_buf.full;
      grant_mem_c = mem_buf.full;
    end
  end

  // Ready depends only on buffer state and grant, never on own VALID.
  assign ALU_READY = !alu_buf.full || grant_alu_c;
  assign MEM_READY = !mem_buf.full || grant_mem_c;

  assign alu_load_c = ALU_VALID && ALU_READY;
  assign mem_load_c = MEM_VALID && MEM_READY;
  assign alu_stay_c = alu_buf.full && !grant_alu_c;
  assign mem_stay_c = mem_buf.full && !grant_mem_c;

  // Holding buffers. A waiting entry becomes older when the other side refills.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      alu_buf <= '0;
      mem_buf <= '0;
    end else begin
      alu_buf.full <= alu_stay_c || alu_load_c;
      mem_buf.full <= mem_stay_c || mem_load_c;
      alu_buf.age  <= alu_stay_c && (mem_load_c || (mem_stay_c && alu_buf.age));
      mem_buf.age  <= mem_stay_c && (alu_load_c || (alu_stay_c && mem_buf.age));
      if (alu_load_c) begin
        alu_buf.addr <= ALU_ADDR;
        alu_buf.data <= ALU_DATA;
      end
      if (mem_load_c) begin
        mem_buf.addr <= MEM_ADDR;
        mem_buf.data <= MEM_DATA;
      end
    end
  end

  // Registered write port; address/data hold when nothing is granted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
    end else begin
      WRITE <= grant_alu_c || grant_mem_c;
      if (grant_mem_c) begin
        INADDRESS <= mem_buf.addr;
        IN        <= mem_buf.data;
      end else if (grant_alu_c) begin
        INADDRESS <= alu_buf.addr;
        IN        <= alu_buf.data;
      end
    end
  end

  // Scoreboard: clear on the commit edge, then set so a new issue wins.
  always_comb begin
    pending_nxt_c = PENDING;
    if (WRITE) begin
      pending_nxt_c[INADDRESS] = 1'b0;
    end
    if (ISSUE_VALID) begin
      pending_nxt_c[ISSUE_ADDR] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      PENDING <= '0;
    end else begin
      PENDING <= pending_nxt_c;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: a table of per-cycle vectors
// (inputs, expected READY before the edge, expected outputs after the edge)
// plus hand-written reset and streaming sequences.
module tb_reg_write_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ALU_VALID = 1'b0;
  logic [2:0] ALU_ADDR = 3'd0;
  logic [7:0] ALU_DATA = 8'd0;
  logic       ALU_READY;
  logic       MEM_VALID = 1'b0;
  logic [2:0] MEM_ADDR = 3'd0;
  logic [7:0] MEM_DATA = 8'd0;
  logic       MEM_READY;
  logic       ISSUE_VALID = 1'b0;
  logic [2:0] ISSUE_ADDR = 3'd0;
  logic       WRITE;
  logic [2:0] INADDRESS;
  logic [7:0] IN;
  logic [7:0] PENDING;

  int checks = 0;
  int failures = 0;

  reg_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(CLK), .RESET(RESET),
    .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
    .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR),
    .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       av; logic [2:0] aa; logic [7:0] ad;
    logic       mv; logic [2:0] ma; logic [7:0] md;
    logic       iv; logic [2:0] ia;
    logic       e_ardy; logic e_mrdy;
    logic       e_w; logic [2:0] e_addr; logic [7:0] e_data; logic [7:0] e_pend;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic av, input logic [2:0] aa, input logic [7:0] ad,
    input logic mv, input logic [2:0] ma, input logic [7:0] md,
    input logic iv, input logic [2:0] ia,
    input logic ear, input logic emr,
    input logic ew, input logic [2:0] eaddr, input logic [7:0] edata, input logic [7:0] ep);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.mv = mv; v.ma = ma; v.md = md;
    v.iv = iv; v.ia = ia;
    v.e_ardy = ear; v.e_mrdy = emr;
    v.e_w = ew; v.e_addr = eaddr; v.e_data = edata; v.e_pend = ep;
    return v;
  endfunction

  task automatic idle_inputs();
    ALU_VALID = 1'b0; MEM_VALID = 1'b0; ISSUE_VALID = 1'b0;
  endtask

  initial begin
    // Single ALU write to r3 = -23 with issue one cycle earlier
    vecs[0]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd3, 1,1, 0,3'd0,8'h00, 8'h08);
    vecs[1]  = mk(1,3'd3,8'hE9, 0,3'd0,8'h00, 0,3'd0, 1,1, 0,3'd0,8'h00, 8'h08);
    vecs[2]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 1,3'd3,8'hE9, 8'h08);
    vecs[3]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 0,3'd3,8'hE9, 8'h00);
    // Contention: ALU r6=35, MEM r2=45 accepted together
    vecs[4]  = mk(1,3'd6,8'd35, 1,3'd2,8'd45, 0,3'd0, 1,1, 0,3'd3,8'hE9, 8'h00);
    vecs[5]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,1, 1,3'd2,8'd45, 8'h00);
    vecs[6]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 1,3'd6,8'd35, 8'h00);
    vecs[7]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 0,3'd6,8'd35, 8'h00);
    // Same address, same edge: MEM first, ALU value is final
    vecs[8]  = mk(1,3'd2,8'd20, 1,3'd2,8'd45, 0,3'd0, 1,1, 0,3'd6,8'd35, 8'h00);
    vecs[9]  = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 0,1, 1,3'd2,8'd45, 8'h00);
    vecs[10] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 1,3'd2,8'd20, 8'h00);
    vecs[11] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 0,3'd2,8'd20, 8'h00);
    // Older ALU r1 beats a younger MEM r1 refill regardless of priority
    vecs[12] = mk(1,3'd1,8'h11, 1,3'd4,8'h44, 0,3'd0, 1,1, 0,3'd2,8'd20, 8'h00);
    vecs[13] = mk(0,3'd0,8'h00, 1,3'd1,8'h55, 0,3'd0, 0,1, 1,3'd4,8'h44, 8'h00);
    vecs[14] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,0, 1,3'd1,8'h11, 8'h00);
    vecs[15] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 1,3'd1,8'h55, 8'h00);
    vecs[16] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 0,3'd1,8'h55, 8'h00);
    // Set/clear collision on r5: set wins
    vecs[17] = mk(1,3'd5,8'h7F, 0,3'd0,8'h00, 1,3'd5, 1,1, 0,3'd1,8'h55, 8'h20);
    vecs[18] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 0,3'd0, 1,1, 1,3'd5,8'h7F, 8'h20);
    vecs[19] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd5, 1,1, 0,3'd5,8'h7F, 8'h20);
    vecs[20] = mk(0,3'd0,8'h00, 0,3'd0,8'h00, 1,3'd0, 1,1, 0,3'd5,8'h7F, 8'h21);

    // Reset held 2 cycles with both requesters valid: nothing gets through
    @(negedge CLK);
    RESET = 1'b1;
    ALU_VALID = 1'b1; ALU_ADDR = 3'd4; ALU_DATA = 8'h5A;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd7; MEM_DATA = 8'hA5;
    ISSUE_VALID = 1'b1; ISSUE_ADDR = 3'd4;
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK); #1;
      chk($sformatf("rst%0d_write", c), 32'(WRITE), 32'd0);
      chk($sformatf("rst%0d_addr", c), 32'(INADDRESS), 32'd0);
      chk($sformatf("rst%0d_data", c), 32'(IN), 32'd0);
      chk($sformatf("rst%0d_pending", c), 32'(PENDING), 32'h00);
    end
    @(negedge CLK);
    RESET = 1'b0;
    idle_inputs();
    #1;
    chk("rst_alu_ready", 32'(ALU_READY), 32'd1);
    chk("rst_mem_ready", 32'(MEM_READY), 32'd1);
    @(posedge CLK); #1;
    chk("rst_idle_write", 32'(WRITE), 32'd0);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      ALU_VALID = vecs[i].av; ALU_ADDR = vecs[i].aa; ALU_DATA = vecs[i].ad;
      MEM_VALID = vecs[i].mv; MEM_ADDR = vecs[i].ma; MEM_DATA = vecs[i].md;
      ISSUE_VALID = vecs[i].iv; ISSUE_ADDR = vecs[i].ia;
      #1;
      chk($sformatf("v%0d_alu_ready", i), 32'(ALU_READY), 32'(vecs[i].e_ardy));
      chk($sformatf("v%0d_mem_ready", i), 32'(MEM_READY), 32'(vecs[i].e_mrdy));
      @(posedge CLK); #1;
      chk($sformatf("v%0d_write", i), 32'(WRITE), 32'(vecs[i].e_w));
      chk($sformatf("v%0d_addr", i), 32'(INADDRESS), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d_data", i), 32'(IN), 32'(vecs[i].e_data));
      chk($sformatf("v%0d_pending", i), 32'(PENDING), 32'(vecs[i].e_pend));
    end

    // Both requesters streaming: ALU r6=0x66, MEM r7=0x77
    @(negedge CLK);
    ALU_VALID = 1'b1; ALU_ADDR = 3'd6; ALU_DATA = 8'h66;
    MEM_VALID = 1'b1; MEM_ADDR = 3'd7; MEM_DATA = 8'h77;
    ISSUE_VALID = 1'b0;
    @(posedge CLK); #1;
    chk("stream_accept_write", 32'(WRITE), 32'd0);
    for (int g = 0; g < 6; g++) begin
      logic       exp_mem;
`ifdef RR_ARB_EN
      exp_mem = ((g % 2) == 0);
`else
      exp_mem = 1'b1;
`endif
      @(posedge CLK); #1;
      chk($sformatf("stream%0d_write", g), 32'(WRITE), 32'd1);
      chk($sformatf("stream%0d_addr", g), 32'(INADDRESS), exp_mem ? 32'd7 : 32'd6);
      chk($sformatf("stream%0d_data", g), 32'(IN), exp_mem ? 32'h77 : 32'h66);
      chk($sformatf("stream%0d_pending", g), 32'(PENDING), 32'h21);
    end

    // Reset with both buffers full discards the in-flight writes
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("rst2_write", 32'(WRITE), 32'd0);
    chk("rst2_addr", 32'(INADDRESS), 32'd0);
    chk("rst2_data", 32'(IN), 32'd0);
    chk("rst2_pending", 32'(PENDING), 32'h00);
    @(negedge CLK);
    RESET = 1'b0;
    idle_inputs();
    #1;
    chk("rst2_alu_ready", 32'(ALU_READY), 32'd1);
    chk("rst2_mem_ready", 32'(MEM_READY), 32'd1);
    @(posedge CLK); #1;
    chk("rst2_no_stale_write", 32'(WRITE), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Write-port arbiter and scoreboard for the 8 x 8 register file. Two writeback requesters (ALU result path and memory-load path) share the register file's single write port through valid/ready handshakes; each requester has a one-entry holding buffer. The block drives the register file's write-data, write-address and write-enable inputs from a registered output stage. It keeps a per-register pending bitmap that the control unit uses to stall dependent instructions.

## Interface
Parameters:
- DATA_W, 8, write-data width
- ADDR_W, 3, register address width (8 registers)

Ports:
- CLK  in  1  clock; all state changes on posedge
- RESET  in  1  synchronous, active-high reset
- ALU_VALID  in  1  ALU writeback request
- ALU_ADDR  in  3  ALU destination register
- ALU_DATA  in  8  ALU result (signed)
- ALU_READY  out  1  ALU buffer can accept this cycle
- MEM_VALID  in  1  memory-load writeback request
- MEM_ADDR  in  3  load destination register
- MEM_DATA  in  8  load data (signed)
- MEM_READY  out  1  MEM buffer can accept this cycle
- ISSUE_VALID  in  1  instruction with a register destination issued
- ISSUE_ADDR  in  3  destination of the issued instruction
- WRITE  out  1  register file write enable (registered)
- INADDRESS  out  3  register file write address (registered)
- IN  out  8  register file write data (registered)
- PENDING  out  8  bit i = register i has an outstanding write

## Operation
- Handshake: a transfer occurs at a posedge where VALID && READY. The requester must hold ADDR/DATA stable while VALID && !READY.
- READY = buffer empty OR buffer is granted this cycle (same-cycle drain and refill allowed).
- Each buffer stores {full, addr, data, age}. age = 1 when the entry is older than the other full buffer.
- Arbitration runs each cycle over the full buffers. The grant loads the output stage at the edge and frees that buffer.
- Output stage: on a grant, WRITE=1 and INADDRESS/IN take the buffer contents. With no grant, WRITE=0 and INADDRESS/IN hold their previous values.
- Default arbitration is fixed priority: MEM over ALU.
- Ordering rule (overrides arbitration): if both buffers are full with equal addresses, the older entry is granted first. If both were accepted at the same edge, MEM is granted first, so the ALU value is the final one.
- Scoreboard:
  - ISSUE_VALID sets PENDING[ISSUE_ADDR] at the edge.
  - A bit is cleared at the edge where WRITE=1 with INADDRESS equal to that bit, which is the register file commit edge.
  - If a set and a clear hit the same bit at the same edge, the set wins.
- RESET (any cycle, including with buffers full): both buffers empty, WRITE=0, INADDRESS=0, IN=0, PENDING=0. In-flight writes are discarded. READY outputs are 1 in the first cycle after reset.

## Timing
- Request accepted at edge k. The earliest grant is at edge k+1, where WRITE rises. The register file updates at edge k+2 (plus its internal #1), and PENDING clears at edge k+2.
- Minimum accept-to-register latency is 2 cycles. With both buffers full, the losing request waits 1 extra cycle.
- Throughput: one register file write per cycle sustained. With both requesters streaming, each gets at least every other cycle under round-robin; under fixed priority, ALU can starve while MEM streams.
- ALU_READY/MEM_READY are combinational from buffer state and the current grant. They never depend combinationally on the same requester's VALID.
- Every output is reset-deterministic on the first posedge with RESET=1.

## Configuration
- RR_ARB_EN defined: round-robin arbitration. A 1-bit last-grant register (reset to ALU) gives priority to the requester not granted last. The ordering rule still overrides.
- RR_ARB_EN undefined: fixed priority MEM over ALU. No last-grant register is present.

## Test plan
- Reset: RESET=1 for 2 cycles with both VALID=1 -> WRITE=0, PENDING=8'h00, no transfers. After release, both READY=1.
- Single ALU write: ISSUE_ADDR=3 at edge 0; ALU_VALID, ALU_ADDR=3, ALU_DATA=-23 at edge 1 -> WRITE=1, INADDRESS=3, IN=-23 after edge 2; PENDING[3] clears at edge 3.
- Contention: both requesters accepted at the same edge (ALU r6=35, MEM r2=45) -> r2 written first, then r6 on the next cycle. ALU_READY=0 during the waiting cycle.
- Same-address order: ALU r2=20 and MEM r2=45 accepted at the same edge -> two writes, MEM first. r2 finally reads 20.
- Set/clear collision: ISSUE_ADDR=5 at the same edge as the commit of a write to r5 -> PENDING[5] stays 1.
- Round-robin (RR_ARB_EN): both VALID held high for 6 cycles -> grants alternate starting with MEM, with no requester granted twice in a row. Without the macro, MEM wins all 6 grants.
